// File: rtl/ca5_q1_seq_detector.sv
// Overlapping serial detector for the pattern 1001.
// Moore FSM: w is decoded from the state register only.
module ca5_q1_seq_detector (
    input  logic clk,
    input  logic rst,
    input  logic j,
    output logic w
);

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b010;
    localparam logic [2:0] S3 = 3'b011;
    localparam logic [2:0] S4 = 3'b100;

    // Power-up value lets the block work with rst tied low.
    logic [2:0] state = S0;
    logic [2:0] state_nxt;

    always_comb begin
        state_nxt = S0;
        case (state)
            S0:      state_nxt = j ? S1 : S0;
            S1:      state_nxt = j ? S1 : S2;
            S2:      state_nxt = j ? S1 : S3;
            S3:      state_nxt = j ? S4 : S0;
            // Trailing 1 of a match is the head of the next one.
            S4:      state_nxt = j ? S1 : S2;
            default: state_nxt = S0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    assign w = (state == S4);

endmodule

// File: tb/tb_ca5_q1_seq_detector.sv
// Bench for ca5_q1_seq_detector: directed cases plus a random
// stream, checked against a last-four-bits history model.
module tb_ca5_q1_seq_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic j   = 1'b0;
    logic w;

    int errors = 0;
    int checks = 0;

    // Reference: bits sampled since reset, newest in bit 0.
    logic [3:0] hist = 4'b0000;
    int nbits = 0;
    logic exp_w = 1'b0;
    logic prev_w = 1'b0;
    int pulses = 0;

    ca5_q1_seq_detector dut (
        .clk(clk),
        .rst(rst),
        .j  (j),
        .w  (w)
    );

    always #100 clk = ~clk;

    task automatic check(input logic obs, input logic expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: w=%0b expected %0b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_sample(input logic b);
        hist = {hist[2:0], b};
        nbits++;
        exp_w = (nbits >= 4) && (hist == 4'b1001);
    endtask

    task automatic model_reset();
        hist = 4'b0000;
        nbits = 0;
        exp_w = 1'b0;
        prev_w = 1'b0;
    endtask

    // Drive b 10 ns before the next rising edge, check 1 ns after it.
    task automatic step(input logic b, input string tag);
        @(negedge clk);
        #90 j = b;
        @(posedge clk);
        #1;
        model_sample(b);
        check(w, exp_w, tag);
        checks++;
        assert (!(prev_w && w)) else begin
            errors++;
            $error("FAIL %s_one_cycle: w=%0b expected 0 (was high last cycle)",
                   tag, w);
        end
        if (w === 1'b1) pulses++;
        prev_w = w;
    endtask

    task automatic stream(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], tag);
        end
    endtask

    // Called just after an edge: reset mid-cycle and hold it over an edge.
    task automatic pulse_reset(input string tag);
        #49 rst = 1'b1;
        #1;
        check(w, 1'b0, {tag, "_async"});
        model_reset();
        @(negedge clk);
        #90 j = 1'b1;
        @(posedge clk);
        #1;
        check(w, 1'b0, {tag, "_held"});
        #50 rst = 1'b0;
    endtask

    task automatic expect_pulses(input int n, input string tag);
        checks++;
        assert (pulses == n) else begin
            errors++;
            $error("FAIL %s: pulses=%0d expected %0d", tag, pulses, n);
        end
        pulses = 0;
    endtask

    initial begin
        logic b;

        // Power-up without reset: first edge samples j=0.
        @(posedge clk);
        #1;
        model_sample(1'b0);
        check(w, 1'b0, "powerup");
        prev_w = w;

        // 1,1,0,0,1,0,0,1,0,1: detects after the 5th and 8th bits.
        pulses = 0;
        stream(16'b1100100101, 10, "stream10");
        expect_pulses(2, "stream10_pulses");

        pulse_reset("rst1");

        // Overlap: 1,0,0,1,0,0,1 -> two pulses.
        stream(16'b1001001, 7, "overlap");
        expect_pulses(2, "overlap_pulses");

        pulse_reset("rst2");

        // Near misses.
        stream(16'b1010001, 7, "miss_a");
        stream(16'b1111, 4, "miss_b");
        expect_pulses(0, "miss_pulses");

        pulse_reset("rst3");

        // Partial 100 is discarded by reset; a lone 1 must not detect.
        stream(16'b100, 3, "partial");
        pulse_reset("rst4");
        step(1'b1, "after_rst");
        stream(16'b001, 3, "after_rst_full");
        expect_pulses(1, "after_rst_pulses");

        // Reset while w is high drops it at once.
        stream(16'b1001, 4, "pre_rst_hit");
        check(w, 1'b1, "pre_rst_high");
        pulse_reset("rst5");

        // Random stream, mid-cycle glitches on j, occasional resets.
        for (int i = 0; i < 1000; i++) begin
            b = 1'($urandom_range(0, 1));
            step(b, "random");
            #20 j = 1'($urandom_range(0, 1));
            #20 j = ~j;
            if ($urandom_range(0, 63) == 0) begin
                #8;
                pulse_reset("rnd_rst");
            end else begin
                #9;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
